// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and state encoding for the systolic-array sequencer
package tpu_pkg;

    localparam int ARRAY_SIZE = 3;
    localparam int DATA_W     = 8;
    localparam int ACC_W      = 16;
    localparam int N_ROWS     = 3;
    localparam int PIPE_LAT   = 2;
    localparam int IDX_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        FLUSH,
        DONE
    } state_e;

endpackage

// File: rtl/tpu_result_bank.sv
// rtl/tpu_result_bank.sv - per-column result capture with registered read port
// Optional ReLU clamp on capture when TPU_SEQ_RELU_EN is defined.
module tpu_result_bank #(
    parameter int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
    parameter int ACC_W      = tpu_pkg::ACC_W,
    parameter int N_ROWS     = tpu_pkg::N_ROWS,
    parameter int ROW_W      = $clog2(tpu_pkg::N_ROWS)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic [ARRAY_SIZE-1:0]              wr_en_i,
    input  logic [ARRAY_SIZE-1:0][ROW_W-1:0]   wr_row_i,
    input  logic [ARRAY_SIZE-1:0][ACC_W-1:0]   wr_data_i,
    input  logic                               rd_en_i,
    input  logic [tpu_pkg::IDX_W-1:0]          rd_idx_i,
    output logic [ACC_W-1:0]                   rd_data_o
);
    import tpu_pkg::*;

    localparam int N_RES = N_ROWS * ARRAY_SIZE;

    logic [N_RES-1:0][ACC_W-1:0]      mem_q;
    logic [ACC_W-1:0]                 rd_data_q;
    logic [ARRAY_SIZE-1:0][ACC_W-1:0] wr_val;

    always_comb begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
`ifdef TPU_SEQ_RELU_EN
            wr_val[k] = wr_data_i[k][ACC_W-1] ? '0 : wr_data_i[k];
`else
            wr_val[k] = wr_data_i[k];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q     <= '0;
            rd_data_q <= '0;
        end else begin
            if (clear_i) begin
                mem_q <= '0;
            end else begin
                for (int k = 0; k < ARRAY_SIZE; k++) begin
                    if (wr_en_i[k]) begin
                        mem_q[IDX_W'(int'(wr_row_i[k]) * ARRAY_SIZE + k)] <= wr_val[k];
                    end
                end
            end
            if (rd_en_i) begin
                rd_data_q <= (int'(rd_idx_i) < N_RES) ? mem_q[rd_idx_i] : '0;
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tpu_seq_ctrl.sv
// rtl/tpu_seq_ctrl.sv - job sequencer feeding weights/rows into the 3x3 systolic array
// Build option: TPU_SEQ_RELU_EN (clamps negative results to zero in tpu_result_bank).
module tpu_seq_ctrl #(
    parameter int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
    parameter int DATA_W     = tpu_pkg::DATA_W,
    parameter int ACC_W      = tpu_pkg::ACC_W,
    parameter int N_ROWS     = tpu_pkg::N_ROWS,
    parameter int PIPE_LAT   = tpu_pkg::PIPE_LAT
) (
    input  logic                                    caravel_wb_clk_i,
    input  logic                                    caravel_wb_rst_n_i,
    input  logic                                    start_i,
    input  logic                                    abort_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    input  logic                                    w_valid_i,
    output logic                                    w_ready_o,
    input  logic [31:0]                             w_data_i,
    input  logic                                    in_valid_i,
    output logic                                    in_ready_o,
    input  logic [ARRAY_SIZE*DATA_W-1:0]            in_data_i,
    output logic                                    sa_en_o,
    output logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] sa_w_o,
    output logic [ARRAY_SIZE*DATA_W-1:0]            sa_in_o,
    input  logic [ACC_W-1:0]                        sa_o1_i,
    input  logic [ACC_W-1:0]                        sa_o2_i,
    input  logic [ACC_W-1:0]                        sa_o3_i,
    input  logic                                    rd_en_i,
    input  logic [tpu_pkg::IDX_W-1:0]               rd_idx_i,
    output logic [ACC_W-1:0]                        rd_data_o
);
    import tpu_pkg::*;

    localparam int EN_TOTAL = N_ROWS + ARRAY_SIZE - 1 + PIPE_LAT;
    localparam int CNT_W    = $clog2(EN_TOTAL + 1);
    localparam int ROW_W    = $clog2(N_ROWS);
    localparam int COL_W    = $clog2(ARRAY_SIZE);
    localparam int LANE_W   = ARRAY_SIZE * DATA_W;

    state_e                         state_q, state_d;
    logic [COL_W-1:0]               w_cnt_q, w_cnt_d;
    logic [ROW_W-1:0]               row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]               en_cnt_q, en_cnt_d;
    logic                           sa_en_q, sa_en_d;
    logic [LANE_W-1:0]              sa_in_q, sa_in_d;
    logic [ARRAY_SIZE*LANE_W-1:0]   sa_w_q, sa_w_d;
    logic [CNT_W:0]                 issued;
    logic                           bank_clr;
    logic                           unused_w_hi;

    logic [ARRAY_SIZE-1:0]              cap_en;
    logic [ARRAY_SIZE-1:0][ROW_W-1:0]   cap_row;
    logic [ARRAY_SIZE-1:0][ACC_W-1:0]   cap_data;

    assign unused_w_hi = ^w_data_i[31:LANE_W];

    always_comb begin
        state_d   = state_q;
        w_cnt_d   = w_cnt_q;
        row_cnt_d = row_cnt_q;
        en_cnt_d  = en_cnt_q;
        sa_en_d   = 1'b0;
        sa_in_d   = '0;
        sa_w_d    = sa_w_q;
        bank_clr  = 1'b0;
        // enabled cycles already handed to the array, including the one presented now
        issued    = {1'b0, en_cnt_q} + {{CNT_W{1'b0}}, sa_en_q};
        if (sa_en_q) begin
            en_cnt_d = en_cnt_q + CNT_W'(1);
        end
        if (abort_i) begin
            state_d   = IDLE;
            w_cnt_d   = '0;
            row_cnt_d = '0;
            en_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d   = LOAD_W;
                        w_cnt_d   = '0;
                        row_cnt_d = '0;
                        en_cnt_d  = '0;
                        bank_clr  = 1'b1;
                    end
                end
                LOAD_W: begin
                    if (w_valid_i) begin
                        sa_w_d[w_cnt_q*LANE_W +: LANE_W] = w_data_i[LANE_W-1:0];
                        if (w_cnt_q == COL_W'(ARRAY_SIZE - 1)) begin
                            state_d = STREAM;
                            w_cnt_d = '0;
                        end else begin
                            w_cnt_d = w_cnt_q + COL_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (in_valid_i) begin
                        sa_en_d = 1'b1;
                        sa_in_d = in_data_i;
                        if (row_cnt_q == ROW_W'(N_ROWS - 1)) begin
                            state_d   = FLUSH;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + ROW_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    sa_en_d = (issued < (CNT_W+1)'(EN_TOTAL));
                    if (sa_en_q && en_cnt_q == CNT_W'(EN_TOTAL - 1)) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
        if (!caravel_wb_rst_n_i) begin
            state_q   <= IDLE;
            w_cnt_q   <= '0;
            row_cnt_q <= '0;
            en_cnt_q  <= '0;
            sa_en_q   <= 1'b0;
            sa_in_q   <= '0;
            sa_w_q    <= '0;
        end else begin
            state_q   <= state_d;
            w_cnt_q   <= w_cnt_d;
            row_cnt_q <= row_cnt_d;
            en_cnt_q  <= en_cnt_d;
            sa_en_q   <= sa_en_d;
            sa_in_q   <= sa_in_d;
            sa_w_q    <= sa_w_d;
        end
    end

    // Column k emits row r = e - PIPE_LAT - k during enabled cycle e.
    assign cap_data = {sa_o3_i, sa_o2_i, sa_o1_i};

    always_comb begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            cap_en[k]  = sa_en_q
                         && ({1'b0, en_cnt_q} >= (CNT_W+1)'(PIPE_LAT + k))
                         && ({1'b0, en_cnt_q} <  (CNT_W+1)'(PIPE_LAT + k + N_ROWS));
            cap_row[k] = ROW_W'({1'b0, en_cnt_q} - (CNT_W+1)'(PIPE_LAT + k));
        end
    end

    tpu_result_bank #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ACC_W      (ACC_W),
        .N_ROWS     (N_ROWS),
        .ROW_W      (ROW_W)
    ) u_bank (
        .clk_i      (caravel_wb_clk_i),
        .rst_ni     (caravel_wb_rst_n_i),
        .clear_i    (bank_clr),
        .wr_en_i    (cap_en),
        .wr_row_i   (cap_row),
        .wr_data_i  (cap_data),
        .rd_en_i    (rd_en_i),
        .rd_idx_i   (rd_idx_i),
        .rd_data_o  (rd_data_o)
    );

    assign busy_o     = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == FLUSH);
    assign done_o     = (state_q == DONE);
    assign w_ready_o  = (state_q == LOAD_W);
    assign in_ready_o = (state_q == STREAM);
    assign sa_en_o    = sa_en_q;
    assign sa_in_o    = sa_in_q;
    assign sa_w_o     = sa_w_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb/tb_tpu_seq_ctrl.sv - directed self-checking bench for tpu_seq_ctrl with a behavioural 3x3 array
module tb_tpu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i, abort_i;
    logic        busy_o, done_o;
    logic        w_valid_i, w_ready_o;
    logic [31:0] w_data_i;
    logic        in_valid_i, in_ready_o;
    logic [23:0] in_data_i;
    logic        sa_en_o;
    logic [71:0] sa_w_o;
    logic [23:0] sa_in_o;
    logic [15:0] sa_o [0:2];
    logic        rd_en_i;
    logic [3:0]  rd_idx_i;
    logic [15:0] rd_data_o;

    int n_checks = 0;
    int n_errs   = 0;

    tpu_seq_ctrl dut (
        .caravel_wb_clk_i   (clk),
        .caravel_wb_rst_n_i (rst_n),
        .start_i            (start_i),
        .abort_i            (abort_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .w_valid_i          (w_valid_i),
        .w_ready_o          (w_ready_o),
        .w_data_i           (w_data_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_data_i          (in_data_i),
        .sa_en_o            (sa_en_o),
        .sa_w_o             (sa_w_o),
        .sa_in_o            (sa_in_o),
        .sa_o1_i            (sa_o[0]),
        .sa_o2_i            (sa_o[1]),
        .sa_o3_i            (sa_o[2]),
        .rd_en_i            (rd_en_i),
        .rd_idx_i           (rd_idx_i),
        .rd_data_o          (rd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: remembers each enabled row, column k shows row e-2-k, junk otherwise.
    int                 en_m;
    logic signed [15:0] rows_m [0:7][0:2];
    logic signed [15:0] w_m    [0:2][0:2];
    int                 r_m    [0:2];
    logic signed [15:0] acc_m  [0:2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_m <= 0;
        end else if (abort_i || start_i) begin
            en_m <= 0;
        end else if (sa_en_o) begin
            if (en_m < 8) begin
                for (int j = 0; j < 3; j++) begin
                    rows_m[en_m][j] <= {{8{sa_in_o[j*8+7]}}, sa_in_o[j*8 +: 8]};
                end
            end
            en_m <= en_m + 1;
        end
    end

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                w_m[j][k] = {{8{sa_w_o[j*24+k*8+7]}}, sa_w_o[j*24+k*8 +: 8]};
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            r_m[k]   = en_m - 2 - k;
            acc_m[k] = 16'sh0;
            if (r_m[k] >= 0 && r_m[k] < 3) begin
                for (int j = 0; j < 3; j++) begin
                    acc_m[k] = acc_m[k] + rows_m[r_m[k]][j] * w_m[j][k];
                end
            end
            sa_o[k] = (sa_en_o && r_m[k] >= 0 && r_m[k] < 3) ? acc_m[k] : 16'hBEEF;
        end
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d);
        w_valid_i = 1'b1;
        w_data_i  = d;
        tick();
        w_valid_i = 1'b0;
    endtask

    task automatic send_row(input logic [23:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done_o && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic rd(input int idx, output logic [15:0] d);
        rd_en_i  = 1'b1;
        rd_idx_i = 4'(idx);
        tick();
        rd_en_i  = 1'b0;
        d        = rd_data_o;
    endtask

    task automatic load_identity();
        send_w(32'hAB000001);
        send_w(32'hCD000100);
        send_w(32'hEF010000);
    endtask

`ifdef TPU_SEQ_RELU_EN
    localparam logic [15:0] NEG4 = 16'h0000;
    localparam logic [15:0] NEG7 = 16'h0000;
`else
    localparam logic [15:0] NEG4 = 16'hFFFC;
    localparam logic [15:0] NEG7 = 16'hFFF9;
`endif

    logic [15:0] d;
    int          n;
    int          gap_en;
    logic [15:0] t3_exp [0:8] = '{16'd3, 16'd2, 16'd1, 16'd6, 16'd5, 16'd4, 16'd9, 16'd8, 16'd7};

    initial begin
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        w_valid_i = 1'b0; w_data_i = '0; in_valid_i = 1'b0; in_data_i = '0;
        rd_en_i = 1'b0; rd_idx_i = '0;
        tick(); tick();
        check("rst_ctl", {busy_o, done_o, w_ready_o, in_ready_o, sa_en_o}, 5'b0);
        check("rst_sa_w", sa_w_o, 72'h0);
        check("rst_sa_in", sa_in_o, 24'h0);
        check("rst_rd", rd_data_o, 16'h0);
        rst_n = 1'b1;
        tick();

        // 1: identity weights, back-to-back rows
        start_job();
        check("t1_busy", {busy_o, w_ready_o}, 2'b11);
        load_identity();
        check("t1_sa_w", sa_w_o, 72'h010000_000100_000001);
        check("t1_in_rdy", {in_ready_o, w_ready_o}, 2'b10);
        send_row(24'h030201);
        check("t1_sa_in", {sa_en_o, sa_in_o}, {1'b1, 24'h030201});
        send_row(24'h060504);
        send_row(24'h090807);
        wait_done(n);
        check("t1_done_lat", n, 5);
        check("t1_en_total", en_m, 7);
        check("t1_busy_done", {busy_o, done_o}, 2'b01);
        for (int i = 0; i < 9; i++) begin
            rd(i, d);
            check($sformatf("t1_res%0d", i), d, 16'(i + 1));
        end

        // 2: 5-cycle input gap between rows 1 and 2
        start_job();
        check("t2_restart", {busy_o, done_o}, 2'b10);
        rd(0, d);
        check("t2_cleared", d, 16'h0);
        load_identity();
        send_row(24'h030201);
        send_row(24'h060504);
        gap_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sa_en_o) gap_en++;
        end
        check("t2_gap_en", gap_en, 0);
        send_row(24'h090807);
        wait_done(n);
        check("t2_done_lat", n, 5);
        for (int i = 0; i < 9; i++) begin
            rd(i, d);
            check($sformatf("t2_res%0d", i), d, 16'(i + 1));
        end

        // 3: abort mid-STREAM, restart with a spurious start while busy
        start_job();
        load_identity();
        send_row(24'h030201);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t3_abort", {busy_o, done_o, sa_en_o, in_ready_o}, 4'b0);
        start_job();
        send_w(32'h00000001);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t3_ign_start", {busy_o, w_ready_o}, 2'b11);
        send_w(32'h00000100);
        send_w(32'h00010000);
        send_row(24'h010203);
        send_row(24'h040506);
        send_row(24'h070809);
        wait_done(n);
        check("t3_done_lat", n, 5);
        for (int i = 0; i < 9; i++) begin
            rd(i, d);
            check($sformatf("t3_res%0d", i), d, t3_exp[i]);
        end

        // 4: start+abort together in DONE -> IDLE, bank retained, out-of-range read
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("t4_idle", {busy_o, done_o}, 2'b00);
        rd(4, d);
        check("t4_keep4", d, 16'd5);
        tick();
        check("t4_hold", rd_data_o, 16'd5);
        rd(10, d);
        check("t4_idx10", d, 16'h0);

        // 5: negative result, clamped only with ReLU
        start_job();
        send_w(32'h000000FF);
        send_w(32'h00000100);
        send_w(32'h00010000);
        send_row(24'h030204);
        send_row(24'h060504);
        send_row(24'h090807);
        wait_done(n);
        check("t5_done_lat", n, 5);
        rd(0, d);
        check("t5_res0", d, NEG4);
        rd(6, d);
        check("t5_res6", d, NEG7);
        rd(1, d);
        check("t5_res1", d, 16'd2);

        // 6: reset during FLUSH
        start_job();
        load_identity();
        send_row(24'h030201);
        send_row(24'h060504);
        send_row(24'h090807);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_ctl", {busy_o, done_o, w_ready_o, in_ready_o, sa_en_o}, 5'b0);
        check("t6_sa_w", sa_w_o, 72'h0);
        check("t6_sa_in", sa_in_o, 24'h0);
        check("t6_rd", rd_data_o, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(1, d);
        check("t6_bank1", d, 16'h0);
        rd(0, d);
        check("t6_bank0", d, 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/tpu_seq_ctrl.md
# tpu_seq_ctrl

Sequencer for the 3x3 systolic array in the educational TPU.

- Takes weight words and input rows from upstream valid/ready streams.
- Drives the array's enable, weight and input ports, and counts the skewed drain cycles.
- Captures the nine 16-bit column outputs into a result bank.
- Sits between the Wishbone register slave and the array, so the bus logic no longer infers array timing.

## Interface

Parameters:

- ARRAY_SIZE, 3: rows = columns of the array
- DATA_W, 8: weight/input element width
- ACC_W, 16: result width
- N_ROWS, 3: input rows per job
- PIPE_LAT, 2: enabled cycles from first sa_in beat to first valid sa_o1

Ports:

- caravel_wb_clk_i  in  1  single clock, all logic on rising edge
- caravel_wb_rst_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  job start pulse
- abort_i  in  1  job abort pulse
- busy_o  out  1  job in progress
- done_o  out  1  job complete, results valid
- w_valid_i / w_ready_o  in / out  1 / 1  weight stream handshake
- w_data_i  in  32  weight word; [23:0] used
- in_valid_i / in_ready_o  in / out  1 / 1  input row stream handshake
- in_data_i  in  24  input row, 3 lanes of DATA_W
- sa_en_o  out  1  array advance enable
- sa_w_o  out  ARRAY_SIZE²·DATA_W (72)  weight matrix
- sa_in_o  out  ARRAY_SIZE·DATA_W (24)  row into array
- sa_o1_i, sa_o2_i, sa_o3_i  in  ACC_W each  array column outputs
- rd_en_i  in  1  result read strobe
- rd_idx_i  in  4  result index r·3+k
- rd_data_o  out  ACC_W  result read data

## Operation

- States and transitions:
  - IDLE → LOAD_W on start_i.
  - LOAD_W → STREAM after ARRAY_SIZE weight beats.
  - STREAM → FLUSH after N_ROWS input beats.
  - FLUSH → DONE after ARRAY_SIZE−1+PIPE_LAT enabled cycles.
  - DONE → LOAD_W on start_i.
  - Any state → IDLE on abort_i.
- LOAD_W:
  - w_ready_o=1.
  - Beat i writes w_data_i[23:0] to sa_w_o[i·24 +: 24], i.e. row i of W; lane j is column j.
  - w_data_i[31:24] is ignored.
- STREAM:
  - in_ready_o=1.
  - sa_en_o=1 only on a handshake beat, with sa_in_o=in_data_i registered.
  - No valid input → sa_en_o=0; the array stalls and does not advance.
- FLUSH:
  - sa_en_o=1 every cycle, sa_in_o=0.
- Capture:
  - An enabled-cycle counter e starts at 0 on the first STREAM beat.
  - Column k (0..2) output at enabled cycle e is result[r][k], with r=e−PIPE_LAT−k.
  - It is stored when 0≤r<N_ROWS.
  - Total enabled cycles per job = N_ROWS+ARRAY_SIZE−1+PIPE_LAT = 7.
- Required math, produced by the array: result[r][k] = Σj in[r][j]·W[j][k]. The controller does no arithmetic except the optional ReLU.
- start_i:
  - Clears the result bank and counters.
  - Ignored while busy_o=1.
- abort_i:
  - Goes to IDLE and clears counters and sa_en_o.
  - The result bank is retained.
  - If start_i and abort_i are asserted in the same cycle, abort wins.
- Reads: rd_idx_i ≥ 9 returns 0.

## Timing

- Reset values:
  - State IDLE; busy_o=0, done_o=0; w_ready_o=0, in_ready_o=0.
  - sa_en_o=0, sa_w_o=0, sa_in_o=0, rd_data_o=0.
  - Result bank all zeros.
- busy_o is high in LOAD_W, STREAM and FLUSH, from the cycle after the accepted start_i.
- done_o:
  - Level signal, high for the whole of DONE.
  - Drops the cycle after start_i or abort_i.
- sa_en_o and sa_in_o are registered: the beat handshaked in cycle t appears at the array in cycle t+1.
- sa_w_o is registered and held stable from end of LOAD_W until the next start_i.
- Capture samples sa_oX_i in the same cycle sa_en_o=1 is presented, so the array outputs must be combinational off its registers.
- rd_data_o is registered: rd_en_i in cycle t gives data in cycle t+1. Without rd_en_i, rd_data_o holds its value.
- Reset asserted mid-job returns to IDLE immediately. Nothing is retained.

## Configuration

- Macro TPU_SEQ_RELU_EN.
  - Defined: at capture, any value with bit ACC_W−1 set (negative, signed) is stored as 0.
  - Undefined: values are stored unmodified.
- Reads and handshakes are identical either way.

## Structure

- Package tpu_pkg holds:
  - state encoding: IDLE, LOAD_W, STREAM, FLUSH, DONE
  - ARRAY_SIZE, DATA_W, ACC_W, N_ROWS, PIPE_LAT
  - result index width
- Sub-module tpu_result_bank holds:
  - 9×ACC_W registers with write-enable per column and clear
  - optional ReLU clamp
  - registered read port

## Test plan

1. Identity W (beats 0x000001, 0x000100, 0x010000); rows 0x030201, 0x060504, 0x090807 → result 1..9 in index order; done_o after 7 enabled cycles.
2. Same job with in_valid_i dropped for 5 cycles between rows 1 and 2 → sa_en_o=0 during the gap; results unchanged.
3. abort_i mid-STREAM, then start_i plus a full job → IDLE then fresh correct results. A second start_i issued while busy is ignored.
4. start_i and abort_i asserted in the same cycle while in DONE → IDLE, results retained; rd_idx_i=10 → 0.
5. With TPU_SEQ_RELU_EN, a weight of 0xFF (−1) producing −4 → stored 0; without the macro → 0xFFFC.
6. Reset asserted during FLUSH → all outputs at reset values next cycle; bank reads 0.
